// File: rtl/ppu_bg_pixel_pipe.sv
// PPU background fetcher (MAP/LO/HI/PUSH) feeding a pixel FIFO that emits one BGP-mapped pixel per cycle.
// Optional `PPU_FINE_SCROLL_EN: discard the first scx[2:0] pixels of each line for fine horizontal scroll.
module ppu_bg_pixel_pipe #(
  parameter int          LINE_W     = 160,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MAP0_BASE  = 16'h9800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic        map_sel,
  input  logic        tile_sel,
  input  logic [7:0]  bgp,
  output logic        vram_rd,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [1:0]  px_out,
  output logic        px_valid,
  output logic [7:0]  px_x,
  output logic        line_done,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 8) begin : g_depth_chk
    $error("ppu_bg_pixel_pipe: FIFO_DEPTH must be at least 8");
  end

  typedef enum logic [2:0] {S_IDLE, S_MAP, S_LO, S_HI, S_PUSH} state_e;

  state_e        state_q, state_d;
  logic [7:0]    ly_q, scy_q, tile_no_q, lo_q, hi_q, emit_q, px_x_q;
  logic [4:0]    coarse_q, tile_x_q;
  logic          map_sel_q, tile_sel_q, hi_fresh_q, busy_q, line_done_q, px_valid_q;
  logic [1:0]    px_out_q;
  logic [1:0]    fifo_q [FIFO_DEPTH];
  logic [1:0]    fifo_d [FIFO_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    row_y, hi_w;
  logic [4:0]    col;
  logic [15:0]   map_base;
  logic          end_line, push, pop, discard;
  int            base;
  logic [2:0]    k;
`ifdef PPU_FINE_SCROLL_EN
  logic [2:0]    fine_q, disc_q;
`endif

  function automatic logic [15:0] tile_addr(input logic [7:0] tno, input logic unsigned_mode);
    if (unsigned_mode) return 16'h8000 + {4'b0, tno, 4'b0};
    else               return 16'h9000 + {{4{tno[7]}}, tno, 4'b0};
  endfunction

  assign row_y    = scy_q + ly_q;
  assign col      = coarse_q + tile_x_q;
  assign map_base = map_sel_q ? (MAP0_BASE + 16'h0400) : MAP0_BASE;
  assign end_line = busy_q && (emit_q == 8'(LINE_W));
  assign push     = (state_q == S_PUSH) && (int'(cnt_q) <= FIFO_DEPTH - 8);
  assign pop      = busy_q && (cnt_q != '0) && (emit_q < 8'(LINE_W));
  // The HI byte arrives during the first PUSH cycle; later PUSH cycles use the held copy.
  assign hi_w     = hi_fresh_q ? vram_data : hi_q;
`ifdef PPU_FINE_SCROLL_EN
  assign discard  = pop && (disc_q < fine_q);
`else
  assign discard  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAP:   state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_PUSH;
      S_PUSH:  if (push) state_d = S_MAP;
      default: state_d = state_q;
    endcase
    if (end_line)   state_d = S_IDLE;
    if (line_start) state_d = S_MAP;
  end

  always_comb begin
    vram_rd   = 1'b0;
    vram_addr = '0;
    case (state_q)
      S_MAP: begin
        vram_rd   = 1'b1;
        vram_addr = map_base + {6'b0, row_y[7:3], 5'b0} + {11'b0, col};
      end
      S_LO: begin
        vram_rd   = 1'b1;
        vram_addr = tile_addr(vram_data, tile_sel_q) + {12'b0, row_y[2:0], 1'b0};
      end
      S_HI: begin
        vram_rd   = 1'b1;
        vram_addr = tile_addr(tile_no_q, tile_sel_q) + {12'b0, row_y[2:0], 1'b0} + 16'd1;
      end
      default: ;
    endcase
  end

  // Shift-down FIFO: head is entry 0; a push lands just above the surviving entries.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    base   = int'(cnt_q);
    k      = '0;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[FIFO_DEPTH-1] = 2'b00;
      cnt_d = cnt_q - CW'(1);
      base  = int'(cnt_q) - 1;
    end
    if (push) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (j >= base && j < base + 8) begin
          k         = 3'(j - base);
          fifo_d[j] = {hi_w[3'd7 - k], lo_q[3'd7 - k]};
        end
      end
      cnt_d = cnt_d + CW'(8);
    end
    if (line_start || end_line) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ly_q <= '0; scy_q <= '0; coarse_q <= '0; map_sel_q <= 1'b0; tile_sel_q <= 1'b0;
      tile_x_q <= '0; tile_no_q <= '0; lo_q <= '0; hi_q <= '0; hi_fresh_q <= 1'b0;
      cnt_q <= '0; emit_q <= '0; busy_q <= 1'b0; line_done_q <= 1'b0;
      px_valid_q <= 1'b0; px_out_q <= '0; px_x_q <= '0;
`ifdef PPU_FINE_SCROLL_EN
      fine_q <= '0; disc_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (line_start) begin
        ly_q <= ly; scy_q <= scy; coarse_q <= scx[7:3];
        map_sel_q <= map_sel; tile_sel_q <= tile_sel;
        tile_x_q <= '0; emit_q <= '0; hi_fresh_q <= 1'b0;
        busy_q <= 1'b1; line_done_q <= 1'b0;
        px_valid_q <= 1'b0; px_out_q <= '0; px_x_q <= '0;
`ifdef PPU_FINE_SCROLL_EN
        fine_q <= scx[2:0]; disc_q <= '0;
`endif
      end else begin
        line_done_q <= end_line;
        if (end_line)             busy_q    <= 1'b0;
        if (state_q == S_LO)      tile_no_q <= vram_data;
        if (state_q == S_HI)      lo_q      <= vram_data;
        if (state_q == S_PUSH)    hi_q      <= hi_w;
        hi_fresh_q <= (state_q == S_HI);
        if (push)                 tile_x_q  <= tile_x_q + 5'd1;
        px_valid_q <= pop && !discard;
        if (pop && !discard) begin
          px_out_q <= bgp[{fifo_q[0], 1'b1} -: 2];
          px_x_q   <= emit_q;
          emit_q   <= emit_q + 8'd1;
        end else begin
          px_out_q <= '0;
          px_x_q   <= '0;
        end
`ifdef PPU_FINE_SCROLL_EN
        if (discard) disc_q <= disc_q + 3'd1;
`endif
      end
    end
  end

  assign px_out    = px_out_q;
  assign px_valid  = px_valid_q;
  assign px_x      = px_x_q;
  assign line_done = line_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ppu_bg_pixel_pipe.sv
// Directed bench: a default-depth instance and a FIFO_DEPTH=8 instance driven by the same line controls.
module tb_ppu_bg_pixel_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, line_start, map_sel, tile_sel;
  logic [7:0]  ly, scx, scy, bgp;
  logic [7:0]  mem [65536];

  logic        vram_rd, px_valid, line_done, busy;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data = 8'h00, px_x;
  logic [1:0]  px_out;

  logic        vram_rd_b, px_valid_b, line_done_b, busy_b;
  logic [15:0] vram_addr_b;
  logic [7:0]  vram_data_b = 8'h00, px_x_b;
  logic [1:0]  px_out_b;

  int errors = 0;
  int checks = 0;

  ppu_bg_pixel_pipe u_dut (
    .clk(clk), .rst(rst), .line_start(line_start), .ly(ly), .scx(scx), .scy(scy),
    .map_sel(map_sel), .tile_sel(tile_sel), .bgp(bgp),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .px_out(px_out), .px_valid(px_valid), .px_x(px_x), .line_done(line_done), .busy(busy)
  );

  ppu_bg_pixel_pipe #(.FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .line_start(line_start), .ly(ly), .scx(scx), .scy(scy),
    .map_sel(map_sel), .tile_sel(tile_sel), .bgp(bgp),
    .vram_rd(vram_rd_b), .vram_addr(vram_addr_b), .vram_data(vram_data_b),
    .px_out(px_out_b), .px_valid(px_valid_b), .px_x(px_x_b), .line_done(line_done_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    if (vram_rd)   vram_data   <= mem[vram_addr];
    if (vram_rd_b) vram_data_b <= mem[vram_addr_b];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row 0 of the test line: tile 1 (lo=FF, hi=00) at x 0..7, then tile 0 (lo=A5, hi=3C).
  function automatic logic [1:0] exp_id(input int x);
    logic [1:0] t0 [8];
    t0 = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
    if (x < 8) return 2'd1;
    return t0[x % 8];
  endfunction

  initial begin
    int c, n_b, ld;
    bit done_b;
    rst = 1'b1; line_start = 1'b0; ly = 8'h00; scx = 8'h00; scy = 8'h00;
    map_sel = 1'b0; tile_sel = 1'b1; bgp = 8'hE4;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h9800] = 8'h01;
    mem[16'h8010] = 8'hFF; mem[16'h8011] = 8'h00;
    mem[16'h8000] = 8'hA5; mem[16'h8001] = 8'h3C;

    tick(); tick();
    chk("reset_busy",      16'(busy),      16'd0);
    chk("reset_vram_rd",   16'(vram_rd),   16'd0);
    chk("reset_vram_addr", vram_addr,      16'd0);
    chk("reset_px_valid",  16'(px_valid),  16'd0);
    chk("reset_line_done", 16'(line_done), 16'd0);
    rst = 1'b0;
    tick();

    // Line 1: unscrolled, unsigned tile data.
    line_start = 1'b1; tick(); line_start = 1'b0;
    chk("t1_busy_c0",    16'(busy),    16'd1);
    chk("t1_map_addr",   vram_addr,    16'h9800);
    chk("t1_map_rd",     16'(vram_rd), 16'd1);
    tick(); chk("t1_lo_addr", vram_addr, 16'h8010);
    tick(); chk("t1_hi_addr", vram_addr, 16'h8011);
    tick(); chk("t1_push_rd", 16'(vram_rd), 16'd0);
    tick(); chk("t1_no_px_c4", 16'(px_valid), 16'd0);
    c = 4; n_b = 0; done_b = 1'b0;
    while (c < 700 && !(c >= 166 && done_b)) begin
      tick(); c++;
      if (c <= 164) begin
        chk("t1_px_valid", 16'(px_valid), 16'd1);
        chk("t1_px_x",     16'(px_x),     16'(c - 5));
        chk("t1_px_out",   16'(px_out),   16'(exp_id(c - 5)));
      end
      if (c == 165) begin
        chk("t1_line_done",   16'(line_done), 16'd1);
        chk("t1_busy_drop",   16'(busy),      16'd0);
        chk("t1_px_valid_end",16'(px_valid),  16'd0);
        chk("t1_vram_rd_end", 16'(vram_rd),   16'd0);
      end
      if (c == 166) chk("t1_line_done_pulse", 16'(line_done), 16'd0);
      if (px_valid_b) begin
        chk("d8_px_x",   16'(px_x_b),   16'(n_b));
        chk("d8_px_out", 16'(px_out_b), 16'(exp_id(n_b)));
        n_b++;
      end
      if (line_done_b) done_b = 1'b1;
    end
    chk("d8_line_done_seen", 16'(done_b), 16'd1);
    chk("d8_pixel_count",    16'(n_b),    16'd160);

    // Line 2: signed tile data, ly=3; restarted at cycle 50.
    tile_sel = 1'b0; ly = 8'h03;
    mem[16'h9800] = 8'h80; mem[16'h9801] = 8'h7F;
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick(); chk("t2_lo_addr_80", vram_addr, 16'h8806);
    tick(); tick(); tick();
    tick(); chk("t2_lo_addr_7f", vram_addr, 16'h97F6);
    ld = 0;
    for (int i = 6; i < 50; i++) begin
      tick();
      ld += int'(line_done) + int'(line_done_b);
    end

    // Restart with scx=F8, map 1, palette 1B.
    scx = 8'hF8; map_sel = 1'b1; tile_sel = 1'b1; ly = 8'h00; bgp = 8'h1B;
    line_start = 1'b1; tick(); line_start = 1'b0;
    chk("t5_no_done_on_restart", 16'(ld + int'(line_done)), 16'd0);
    chk("t3_map_addr_1f", vram_addr,    16'h9C1F);
    chk("t5_busy_restart", 16'(busy),   16'd1);
    tick(); tick(); tick();
    tick(); chk("t3_map_addr_wrap", vram_addr, 16'h9C00);
    tick();
    chk("t5_px_valid_c5", 16'(px_valid), 16'd1);
    chk("t5_px_x_c5",     16'(px_x),     16'd0);
    chk("t5_px_out_bgp",  16'(px_out),   16'b10);
    for (int i = 6; i < 30; i++) tick();

    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_busy",      16'(busy),      16'd0);
    chk("t5_rst_vram_rd",   16'(vram_rd),   16'd0);
    chk("t5_rst_vram_addr", vram_addr,      16'd0);
    chk("t5_rst_px_valid",  16'(px_valid),  16'd0);
    chk("t5_rst_px_out",    16'(px_out),    16'd0);
    chk("t5_rst_px_x",      16'(px_x),      16'd0);
    chk("t5_rst_busy_d8",   16'(busy_b),    16'd0);
    ld = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      ld += int'(line_done) + int'(line_done_b) + int'(vram_rd) + int'(px_valid);
    end
    chk("t5_idle_after_rst", 16'(ld), 16'd0);

`ifdef PPU_FINE_SCROLL_EN
    scx = 8'h03; map_sel = 1'b1; tile_sel = 1'b1; bgp = 8'hE4;
    line_start = 1'b1; tick(); line_start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk("t6_no_px_c7",  16'(px_valid), 16'd0);
    tick();
    chk("t6_px_valid_c8", 16'(px_valid), 16'd1);
    chk("t6_px_x_c8",     16'(px_x),     16'd0);
    chk("t6_px_out_c8",   16'(px_out),   16'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_bg_pixel_pipe.md
Name: ppu_bg_pixel_pipe

Overview:
Parametrised background fetcher and pixel FIFO for the PPU DRAW mode. It replaces the fixed 8-pixel shift register and inline tile fetch.
- Adds SCX/SCY scrolling, selectable BG map (LCDC[3]) and tile-data addressing mode (LCDC[4]), BGP palette mapping, configurable line width and FIFO depth.
- Sits between the PPU mode sequencer (which pulses line_start at DRAW entry) and the VRAM port; emits one palette-mapped pixel per cycle to the LCD stage.

Parameters:
LINE_W, 160, visible pixels per line; range 8..255.
FIFO_DEPTH, 16, pixel FIFO entries; must be at least 8 (elaboration error otherwise).
MAP0_BASE, 16'h9800, BG map base when map_sel=0; map_sel=1 uses MAP0_BASE+16'h0400.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
line_start  in  1  one-cycle pulse; latches ly/scx/scy/map_sel/tile_sel and starts the line
ly  in  8  current scanline
scx  in  8  horizontal scroll
scy  in  8  vertical scroll
map_sel  in  1  LCDC[3]
tile_sel  in  1  LCDC[4]; 1 = unsigned from 8000, 0 = signed from 9000
bgp  in  8  BG palette, sampled live on every output pixel
vram_rd  out  1  VRAM read strobe
vram_addr  out  16  VRAM address
vram_data  in  8  read data, valid the cycle after vram_addr/vram_rd
px_out  out  2  palette-mapped shade
px_valid  out  1  px_out valid this cycle
px_x  out  8  screen x of px_out, 0..LINE_W-1
line_done  out  1  one-cycle pulse at end of line
busy  out  1  high from the cycle after line_start until line_done

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst.
- Reset and idle values: all outputs 0, FIFO empty, state IDLE. rst mid-line aborts the line; no line_done is generated.
- Fetcher FSM: IDLE -> MAP -> LO -> HI -> PUSH -> MAP...
  - MAP: vram_rd=1, vram_addr = map base + {row_y[7:3],5'b0} + ((scx[7:3]+tile_x) & 31), with row_y = (scy+ly) mod 256.
  - LO: tile_no <= vram_data. vram_addr = tile address of the incoming vram_data + 2*row_y[2:0], computed combinationally from vram_data.
    - tile_sel=1: 8000 + 16*tno.
    - tile_sel=0: 9000 + 16*signed(tno).
  - HI: lo <= vram_data; vram_addr = tile address + 1, using the latched tile_no.
  - PUSH: hi <= vram_data on entry; vram_rd=0.
    - If FIFO free slots >= 8: push 8 pixels, MSB first, colour id {hi[7-i],lo[7-i]}; tile_x++ (5-bit wrap); go to MAP.
    - Otherwise hold in PUSH with lo/hi retained.
- Output: when the FIFO is non-empty and the emitted count < LINE_W, pop one entry per cycle. px_out = bgp[2*id+1 -: 2]; px_valid=1; px_x = emitted count.
- Latency: first px_valid 5 cycles after the line_start edge. Steady state is 1 pixel/cycle with no underrun (8 pixels fetched per 4 cycles).
- Push and pop in the same cycle are both honoured; count updates by +8-1.
- End of line: the cycle after the LINE_W-th valid pixel, line_done=1, FIFO flushed, FSM to IDLE, vram_rd=0.
- line_start while busy: restart immediately. Flush FIFO, re-latch inputs, reset tile_x and emitted count; no line_done for the aborted line.
- Address arithmetic is 16-bit; map offset wraps within the 32x32 map.

Optional Feature:
PPU_FINE_SCROLL_EN
- Defined: the first scx[2:0] popped entries of each line are discarded (px_valid=0, px_x not advanced). First visible pixel appears (5 + scx[2:0]) cycles after line_start.
- Undefined: no discard; scroll is coarse (tile-aligned) only.

Test Plan:
1. map 9800=01, 8010=FF, 8011=00, bgp=E4, scx=scy=ly=0, tile_sel=1, line_start -> px_valid first at cycle 5, px_out=01 for x=0..7, line_done at cycle 165, busy drops with it.
2. tile_sel=0, map entry 80 then 7F, ly=3 -> LO addresses 8806 then 97F6.
3. scx=F8 (tile_x base 31), map_sel=1 -> MAP reads 9C1F then 9C00 (wrap).
4. FIFO_DEPTH=8, hold in PUSH -> no push while count>0, no pixel lost or duplicated; 160 ids match reference pattern.
5. line_start again at cycle 50 mid-line; rst at cycle 30 of another line -> restart with no line_done; after rst all outputs 0 and state IDLE.
6. PPU_FINE_SCROLL_EN, scx=03 -> first px_valid at cycle 8 showing tile pixel 3, px_x=0.
